// File: rtl/alu_seq.sv
// Instruction sequencer feeding an external combinational ALU: fetches operands
// from a small register file, drives the ALU, and writes the result back.
module alu_seq #(
    parameter int NREG = 4,
    parameter int W    = 8,
    localparam int AW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic          instr_ldi,
    input  logic [4:0]    instr_op,
    input  logic          instr_cin,
    input  logic [AW-1:0] instr_rd,
    input  logic [AW-1:0] instr_ra,
    input  logic [AW-1:0] instr_rb,
    input  logic [W-1:0]  instr_imm,
    output logic [4:0]    alu_sel,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic          alu_cin,
    input  logic [W-1:0]  alu_o,
    output logic          done,
    output logic [W-1:0]  result,
    output logic [7:0]    icount,
    input  logic [AW-1:0] dbg_addr,
    output logic [W-1:0]  dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_ready;
    logic          r_ldi;
    logic [AW-1:0] r_rd;
    logic [W-1:0]  r_imm;
    logic [W-1:0]  r_regs [NREG];
    logic [4:0]    r_sel;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_cin;
    logic          r_done;
    logic [W-1:0]  r_result;
    logic [7:0]    r_icount;
    logic [W-1:0]  w_wdata;

    assign w_wdata = r_ldi ? r_imm : alu_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_ldi    <= 1'b0;
            r_rd     <= '0;
            r_imm    <= '0;
            r_sel    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_cin    <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_icount <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid && r_ready) begin
                        r_ldi   <= instr_ldi;
                        r_rd    <= instr_rd;
                        r_imm   <= instr_imm;
                        r_ready <= 1'b0;
                        if (instr_ldi) begin
                            r_state <= S_WB;
                        end else begin
                            // Operands are read here, after any earlier write-back has landed,
                            // so they are already current while the EXEC cycle runs.
                            r_a     <= r_regs[instr_ra];
                            r_b     <= r_regs[instr_rb];
                            r_sel   <= instr_op;
                            r_cin   <= instr_cin;
                            r_state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    r_state <= S_WB;
                end
                S_WB: begin
                    r_regs[r_rd] <= w_wdata;
                    r_result     <= w_wdata;
                    r_done       <= 1'b1;
                    r_icount     <= r_icount + 8'd1;
                    r_ready      <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_ready = r_ready;
    assign alu_sel     = r_sel;
    assign alu_a       = r_a;
    assign alu_b       = r_b;
    assign alu_cin     = r_cin;
    assign done        = r_done;
    assign result      = r_result;
    assign icount      = r_icount;
    assign dbg_data    = r_regs[dbg_addr];

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a behavioural ALU closes the loop, and a scoreboard holds
// expected write-back values and latencies until the matching done pulse.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic       instr_ready;
    logic       instr_ldi;
    logic [4:0] instr_op;
    logic       instr_cin;
    logic [1:0] instr_rd;
    logic [1:0] instr_ra;
    logic [1:0] instr_rb;
    logic [7:0] instr_imm;
    logic [4:0] alu_sel;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_cin;
    logic [7:0] alu_o;
    logic       done;
    logic [7:0] result;
    logic [7:0] icount;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    always #5 clk = ~clk;

    alu_seq #(.NREG(4), .W(8)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_ldi(instr_ldi), .instr_op(instr_op), .instr_cin(instr_cin),
        .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
        .instr_imm(instr_imm),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_o(alu_o),
        .done(done), .result(result), .icount(icount),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Behavioural ALU: [2] picks logic/arith, [1:0] the function, [4:3] a post-shift.
    function automatic logic [7:0] alu_f(input logic [4:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic cin);
        logic [7:0] r;
        if (op[2]) begin
            case (op[1:0])
                2'd0: r = a & b;
                2'd1: r = a | b;
                2'd2: r = a ^ b;
                default: r = ~a;
            endcase
        end else begin
            case (op[1:0])
                2'd0: r = a;
                2'd1: r = a + {7'd0, cin};
                2'd2: r = a + b + {7'd0, cin};
                default: r = a + ~b + {7'd0, cin};
            endcase
        end
        case (op[4:3])
            2'd0: return r;
            2'd1: return {r[6:0], 1'b0};
            2'd2: return {1'b0, r[7:1]};
            default: return {r[6:0], r[7]};
        endcase
    endfunction

    assign alu_o = alu_f(alu_sel, alu_a, alu_b, alu_cin);

    typedef struct {
        logic [7:0] val;
        int         lat;
        int         acc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_regs [4];
    logic [7:0] m_icount;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Called at the negedge before the accepting clock edge.
    task automatic model_issue(input logic ldi, input logic [4:0] op, input logic cin,
                               input logic [1:0] rd, input logic [1:0] ra,
                               input logic [1:0] rb, input logic [7:0] imm);
        exp_t e;
        e.val = ldi ? imm : alu_f(op, m_regs[ra], m_regs[rb], cin);
        e.lat = ldi ? 1 : 2;
        e.acc = cyc + 1;
        m_regs[rd] = e.val;
        sb.push_back(e);
    endtask

    task automatic model_reset();
        sb.delete();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_icount = 8'h00;
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check_eq("done_unexpected", {31'd0, done}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("result", {24'd0, result}, {24'd0, e.val});
                check_eq("latency", cyc - e.acc, e.lat);
                m_icount = m_icount + 8'd1;
            end
        end
    end

    task automatic send(input logic ldi, input logic [4:0] op, input logic cin,
                        input logic [1:0] rd, input logic [1:0] ra,
                        input logic [1:0] rb, input logic [7:0] imm);
        int g = 0;
        @(negedge clk);
        instr_ldi = ldi; instr_op = op; instr_cin = cin;
        instr_rd = rd; instr_ra = ra; instr_rb = rb; instr_imm = imm;
        instr_valid = 1'b1;
        while (!instr_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        check_eq("send_ready", {31'd0, instr_ready}, 32'd1);
        model_issue(ldi, op, cin, rd, ra, rb, imm);
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((sb.size() != 0 || !instr_ready) && g < 60) begin
            @(negedge clk);
            g++;
        end
        check_eq("drain", sb.size(), 0);
    endtask

    task automatic read_reg(input string tag, input logic [1:0] a, input logic [7:0] exp_v);
        dbg_addr = a;
        #1;
        check_eq(tag, {24'd0, dbg_data}, {24'd0, exp_v});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int last;
        int acc_n;
        reset = 1'b1; instr_valid = 1'b0; instr_ldi = 1'b0; instr_op = 5'd0;
        instr_cin = 1'b0; instr_rd = 2'd0; instr_ra = 2'd0; instr_rb = 2'd0;
        instr_imm = 8'd0; dbg_addr = 2'd0;
        model_reset();

        // 1: reset then idle
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) read_reg("rst_reg", 2'(i), 8'h00);
        check_eq("rst_icount", {24'd0, icount}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_ready", {31'd0, instr_ready}, 32'd1);
        check_eq("rst_result", {24'd0, result}, 32'd0);

        // 2: two LDIs then add
        send(1'b1, 5'b00000, 1'b0, 2'd0, 2'd0, 2'd0, 8'h35);
        send(1'b1, 5'b00000, 1'b0, 2'd1, 2'd0, 2'd0, 8'h4A);
        send(1'b0, 5'b00010, 1'b0, 2'd2, 2'd0, 2'd1, 8'h00);
        drain();
        read_reg("t2_r2", 2'd2, 8'h7F);
        check_eq("t2_result", {24'd0, result}, 32'h7F);
        check_eq("t2_icount", {24'd0, icount}, 32'd3);

        // 3: read-after-write with wrap
        send(1'b1, 5'b00000, 1'b0, 2'd3, 2'd0, 2'd0, 8'hFF);
        send(1'b0, 5'b00001, 1'b1, 2'd3, 2'd3, 2'd0, 8'h00);
        drain();
        read_reg("t3_r3", 2'd3, 8'h00);
        check_eq("t3_result", {24'd0, result}, 32'h00);

        // 4: AND then shift left, rd == rb
        send(1'b1, 5'b00000, 1'b0, 2'd0, 2'd0, 2'd0, 8'hF0);
        send(1'b1, 5'b00000, 1'b0, 2'd1, 2'd0, 2'd0, 8'h3C);
        send(1'b0, 5'b01100, 1'b0, 2'd1, 2'd0, 2'd1, 8'h00);
        check_eq("t4_sel_exec", {27'd0, alu_sel}, 32'b01100);
        check_eq("t4_a_exec", {24'd0, alu_a}, 32'hF0);
        check_eq("t4_b_exec", {24'd0, alu_b}, 32'h3C);
        drain();
        read_reg("t4_r1", 2'd1, 8'h60);
        check_eq("t4_sel_hold", {27'd0, alu_sel}, 32'b01100);

        // 5: valid held high with changing fields
        last = -1;
        acc_n = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            instr_op  = 5'($urandom_range(0, 31));
            instr_cin = 1'($urandom_range(0, 1));
            instr_rd  = 2'($urandom_range(0, 3));
            instr_ra  = 2'($urandom_range(0, 3));
            instr_rb  = 2'($urandom_range(0, 3));
            instr_imm = 8'($urandom_range(0, 255));
            instr_ldi = instr_ready ? 1'b0 : 1'($urandom_range(0, 1));
            instr_valid = 1'b1;
            if (instr_ready) begin
                if (last >= 0) check_eq("t5_ready_gap", cyc - last, 3);
                last = cyc;
                acc_n++;
                model_issue(instr_ldi, instr_op, instr_cin, instr_rd, instr_ra, instr_rb, instr_imm);
            end
        end
        @(negedge clk);
        instr_valid = 1'b0;
        drain();
        check_eq("t5_accepts", acc_n, 8);
        for (int i = 0; i < 4; i++) read_reg("t5_reg", 2'(i), m_regs[i]);
        check_eq("t5_icount", {24'd0, icount}, {24'd0, m_icount});

        // 6: reset during EXEC aborts the write-back
        send(1'b1, 5'b00000, 1'b0, 2'd0, 2'd0, 2'd0, 8'h11);
        send(1'b0, 5'b00000, 1'b0, 2'd2, 2'd0, 2'd0, 8'h00);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("t6_no_done", {31'd0, done}, 32'd0);
        end
        read_reg("t6_r2", 2'd2, 8'h00);
        read_reg("t6_r0", 2'd0, 8'h00);
        check_eq("t6_icount", {24'd0, icount}, 32'd0);
        check_eq("t6_ready", {31'd0, instr_ready}, 32'd1);

        // post-reset sanity: sequencer still works
        send(1'b1, 5'b00000, 1'b0, 2'd1, 2'd0, 2'd0, 8'h5A);
        send(1'b0, 5'b00110, 1'b0, 2'd2, 2'd1, 2'd1, 8'h00);
        drain();
        read_reg("t6_after_r2", 2'd2, 8'h00);
        check_eq("t6_after_icount", {24'd0, icount}, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
FSMD sequencer that sits directly upstream of the 8-bit ALU.
- Accepts one instruction at a time over a valid/ready handshake.
- Reads two operands from an internal 4x8 register file and drives the ALU select, operand and carry inputs.
- Captures the ALU result and writes it back to the register file.
- Also supports load-immediate, so a program can seed registers with no external memory.

Parameters:
- NREG, 4, number of register-file entries; a power of two, with address width log2(NREG).
- W, 8, datapath width; must match the ALU width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- instr_valid  input  1  instruction present on instr_* fields
- instr_ready  output  1  sequencer can accept an instruction this cycle
- instr_ldi  input  1  1 = load immediate, 0 = ALU operation
- instr_op  input  5  ALU select: [1:0] op, [2] logic(1)/arith(0), [4:3] shift
- instr_cin  input  1  ALU carry-in
- instr_rd  input  2  destination register
- instr_ra  input  2  operand-A register
- instr_rb  input  2  operand-B register
- instr_imm  input  W  immediate value for load-immediate
- alu_sel  output  5  to ALU select
- alu_a  output  W  to ALU operand a
- alu_b  output  W  to ALU operand b
- alu_cin  output  1  to ALU carry-in
- alu_o  input  W  ALU result; combinational from alu_sel/alu_a/alu_b/alu_cin
- done  output  1  one-cycle pulse when the write-back completes
- result  output  W  value written at the last write-back; held until the next one
- icount  output  8  completed-instruction counter
- dbg_addr  input  2  debug read address
- dbg_data  output  W  combinational read of register dbg_addr

Behaviour:
Reset (synchronous, active-high):
- Forces state IDLE.
- Clears all registers, alu_sel/alu_a/alu_b/alu_cin, result and icount to 0; done=0; instr_ready=1 in the following cycle.
- Reset asserted in any state aborts the in-flight instruction: no write-back, no done pulse.

States:
- IDLE:
  - instr_ready=1.
  - On instr_valid&instr_ready, latch all instr_* fields.
  - If instr_ldi=1, go to WB with the write value = instr_imm.
  - Otherwise go to EXEC.
- EXEC (1 cycle):
  - instr_ready=0.
  - Registered outputs: alu_a=reg[ra], alu_b=reg[rb], alu_sel=op, alu_cin=cin; these are stable for the whole cycle.
  - Go to WB.
- WB (1 cycle):
  - instr_ready=0.
  - Write value: alu_o sampled at this clock edge for ALU ops; the latched imm for load-immediate.
  - reg[rd] <= write value; result <= write value; done=1 (registered, asserted the cycle after WB); icount <= icount+1.
  - Go to IDLE.

Latency and throughput:
- ALU op accepted at edge T → reg[rd] updated and done high after edge T+2.
- Load-immediate accepted at T → reg[rd] updated and done high after edge T+1.
- Back-to-back: the next instruction may be accepted in the cycle done is high (state IDLE). This gives one ALU op per 3 cycles and one load-immediate per 2 cycles.

Hazards and boundary conditions:
- ALU outputs alu_a/alu_b/alu_sel/alu_cin hold their last values outside EXEC; they are not cleared.
- Operand read happens in EXEC, after any prior write-back, so a read-after-write to the same register always sees the new value. No forwarding is needed.
- rd may equal ra and/or rb: the old values are used as operands and the new value is written.
- instr_valid while instr_ready=0 is ignored; the fields are not sampled.
- icount wraps 255→0.
- dbg_data reflects register contents as of the last clock edge.

Test Plan:
1. Reset then idle: hold reset 2 cycles → all dbg_data reads = 0; icount=0; done=0; instr_ready=1.
2. Two LDIs then add:
   - Stimulus: LDI r0=0x35, LDI r1=0x4A, then op=00010 cin=0 rd=r2 ra=r0 rb=r1.
   - Response: done pulses 3 times; r2=0x7F, result=0x7F; icount=3; the add's done comes 2 cycles after acceptance.
3. Read-after-write:
   - Stimulus: LDI r3=0xFF, then op=00001 cin=1 (a+1) rd=r3 ra=r3.
   - Response: r3=0x00 (wrap); result=0x00.
4. Logic plus shift:
   - Stimulus: r0=0xF0, r1=0x3C; op=01100 (AND, shift left) rd=r1 ra=r0 rb=r1.
   - Response: r1=0x60; alu_sel=01100 during EXEC.
5. Handshake:
   - Stimulus: hold instr_valid high continuously with changing fields.
   - Response: instr_ready pulses once per 3 cycles for ALU ops; only fields present in accepting cycles take effect.
6. Reset mid-op: assert reset in the EXEC cycle of an ALU op targeting r2=0x11 → no done; r2=0 after reset; icount=0.
